fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction fetch stage feeding the yChip datapath: owns the PC, issues word reads to
//  instruction memory over a req/ack handshake, buffers returned words in a small queue,
//  and hands {ins, PC, PC+4} to decode under valid/ready. INT loads entryPoint; the
//  downstream branch/jump result redirects fetch and flushes buffered instructions.
// PARAMETERS
//  QDEPTH    2             instruction queue entries (power of 2, >=2)
//  RESET_PC  32'h00000000  PC value held while idle after reset
// PORTS
//  clk          in   1   clock, all state updates on rising edge
//  rst_n        in   1   asynchronous active-low reset
//  INT          in   1   load entryPoint into PC, flush queue, start fetching
//  entryPoint   in   32  start address taken on INT
//  redir_valid  in   1   branch/jump taken by datapath this cycle
//  redir_pc     in   32  target address for redirect
//  imem_req     out  1   read request; held with imem_addr stable until imem_ack
//  imem_addr    out  32  word address of request
//  imem_ack     in   1   read complete; imem_rdata valid this cycle (may be same cycle as req)
//  imem_rdata   in   32  instruction word
//  ins_valid    out  1   queue head valid
//  ins_ready    in   1   decode accepts head (transfer = ins_valid & ins_ready)
//  ins          out  32  head instruction; 32'h00000013 (NOP) when queue empty
//  PC           out  32  address of head instruction
//  PCp4         out  32  PC + 4 (mod 2^32)
//  fetch_fault  out  1   misaligned target trapped (FETCH_ALIGN_CHECK_EN only; else tied 0)
// BEHAVIOUR
//  Reset: state IDLE, fetch_pc=RESET_PC, queue empty, imem_req=0, ins_valid=0, ins=NOP,
//   PC=RESET_PC, fetch_fault=0. Reset mid-transaction abandons it; no response is kept.
//  States: IDLE (no requests) -> FETCH on INT. FETCH issues when slots free:
//   (queue count + outstanding) < QDEPTH; at most one request outstanding.
//   On ack: push {rdata, fetch_pc}; fetch_pc += 4 (wraps 32'hFFFFFFFC -> 0).
//   FETCH -> DRAIN on INT/redirect while a request is outstanding and not acked that
//   cycle; DRAIN keeps imem_req/imem_addr until ack, discards rdata, then -> FETCH at
//   new pc. Redirect with no outstanding request (or acked same cycle): new pc is
//   issued the following cycle, stale rdata dropped.
//  INT/redirect: queue flushed next cycle regardless of simultaneous pop; fetch_pc <=
//   entryPoint / redir_pc. Priority INT > redir_valid. INT in IDLE, FETCH or DRAIN honoured.
//  Latency: INT at edge N -> imem_req=1, imem_addr=entryPoint during cycle N+1; ack in
//   cycle N+1 -> ins_valid=1 after edge N+2. Zero-wait memory sustains 1 ins/cycle.
//  Queue full: no request issued; ins_valid stays 1 until popped. Push and pop in the
//   same cycle with queue full is legal only when a slot was reserved (never overflows).
//  Empty: ins_valid=0, ins=NOP, PC=PCp4-4 = fetch_pc.
// CONFIGURATION
//  FETCH_ALIGN_CHECK_EN defined: INT/redirect target with addr[1:0]!=0 -> no request,
//   queue flushed, fetch_fault=1 (sticky until next INT or reset), state IDLE.
//  Undefined: addr[1:0] forced to 2'b00 on load; fetch_fault constant 0.
// STRUCTURE
//  fetch_pkg: state encodings (IDLE/FETCH/DRAIN), NOP_INS=32'h00000013, default QDEPTH.
//  Sub-module fetch_queue: QDEPTH x 64-bit {pc, ins} FIFO, push/pop/flush, count output.
//  Top: FSM, fetch_pc register, slot reservation, output muxing.
// TESTING
//  Reset then INT with entryPoint=32'h28, zero-wait ack, ready=1 -> PC sequence 28,2C,30..
//   one per cycle, first ins_valid two edges after INT.
//  ins_ready=0 for 5 cycles -> exactly QDEPTH words fetched, imem_req low after, no loss.
//  Ack delayed 3 cycles, redir_pc=32'h100 asserted while waiting -> DRAIN, stale word
//   discarded, next head PC=0x100.
//  INT and redir_valid same cycle (entryPoint=0x40, redir_pc=0x80) -> head PC=0x40.
//  fetch_pc at 32'hFFFFFFFC -> next request address 0x0, PCp4 of that head = 0.
//  FETCH_ALIGN_CHECK_EN: redirect to 0x102 -> fetch_fault=1, no req; INT 0x28 clears it.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_INS        = 32'h0000_0013;
    localparam int          QDEPTH_DEFAULT = 2;

endpackage

// File: rtl/fetch_queue.sv
// Small {pc, ins} FIFO between instruction memory and decode; flush beats push and pop.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter  int QDEPTH = QDEPTH_DEFAULT,
    localparam int AW     = (QDEPTH > 1) ? $clog2(QDEPTH) : 1,
    localparam int CW     = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic [63:0]   push_data_i,
    input  logic          pop_i,
    input  logic          flush_i,
    output logic [63:0]   head_o,
    output logic [CW-1:0] count_o,
    output logic          empty_o
);

    logic [63:0]   mem_q [QDEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(push_i) - CW'(pop_i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; count/pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC ownership, imem req/ack, queue to decode, INT/redirect handling.
// Optional FETCH_ALIGN_CHECK_EN traps misaligned INT/redirect targets via fetch_fault.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int          QDEPTH   = QDEPTH_DEFAULT,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        INT,
    input  logic [31:0] entryPoint,
    input  logic        redir_valid,
    input  logic [31:0] redir_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        ins_valid,
    input  logic        ins_ready,
    output logic [31:0] ins,
    output logic [31:0] PC,
    output logic [31:0] PCp4,
    output logic        fetch_fault
);

    localparam int            CW       = ((QDEPTH > 1) ? $clog2(QDEPTH) : 1) + 1;
    localparam logic [CW-1:0] QDEPTH_C = CW'(QDEPTH);

    fetch_state_e state_q, state_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic [31:0]  drain_addr_q, drain_addr_d;
    logic         fault_q, fault_d;

    logic         load, bad_target, pending;
    logic [31:0]  target_raw, target;
    logic         q_push, q_pop, q_empty;
    logic [CW-1:0] q_count;
    logic [63:0]  q_head;

    // Redirects are ignored while idle or parked after a trapped target; INT always wins.
    always_comb begin
        load       = INT | (redir_valid && (state_q != ST_IDLE) && !fault_q);
        target_raw = INT ? entryPoint : redir_pc;
`ifdef FETCH_ALIGN_CHECK_EN
        bad_target = load && (target_raw[1:0] != 2'b00);
        target     = target_raw;
`else
        bad_target = 1'b0;
        target     = target_raw & ~32'd3;
`endif
    end

    always_comb begin
        imem_req  = ((state_q == ST_FETCH) && (q_count < QDEPTH_C)) || (state_q == ST_DRAIN);
        imem_addr = (state_q == ST_DRAIN) ? drain_addr_q : fetch_pc_q;
        pending   = imem_req && !imem_ack;
        q_push    = (state_q == ST_FETCH) && imem_req && imem_ack && !load;
        q_pop     = ins_valid && ins_ready;
    end

    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        drain_addr_d = drain_addr_q;
        fault_d      = fault_q;

        if (q_push) fetch_pc_d = fetch_pc_q + 32'd4;
        if ((state_q == ST_DRAIN) && imem_ack) state_d = fault_q ? ST_IDLE : ST_FETCH;

        // An unacked request must still complete, so it is parked in DRAIN at its old address.
        if (load) begin
            if (INT) fault_d = 1'b0;
            fetch_pc_d = target;
            if (pending) begin
                state_d      = ST_DRAIN;
                drain_addr_d = imem_addr;
            end else begin
                state_d = ST_FETCH;
            end
            if (bad_target) begin
                fault_d = 1'b1;
                if (!pending) state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            fetch_pc_q <= RESET_PC;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            fault_q    <= fault_d;
        end
    end

    always_ff @(posedge clk) begin
        drain_addr_q <= drain_addr_d;
    end

    fetch_queue #(.QDEPTH(QDEPTH)) u_queue (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (q_push),
        .push_data_i ({fetch_pc_q, imem_rdata}),
        .pop_i       (q_pop),
        .flush_i     (load),
        .head_o      (q_head),
        .count_o     (q_count),
        .empty_o     (q_empty)
    );

    always_comb begin
        ins_valid = !q_empty;
        ins       = q_empty ? NOP_INS : q_head[31:0];
        PC        = q_empty ? fetch_pc_q : q_head[63:32];
        PCp4      = PC + 32'd4;
    end

`ifdef FETCH_ALIGN_CHECK_EN
    assign fetch_fault = fault_q;
`else
    assign fetch_fault = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit: expected {PC, ins} stream per fetch target.
module tb_fetch_unit;

    localparam int          QDEPTH = 2;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        INT, redir_valid, ins_ready;
    logic [31:0] entryPoint, redir_pc;
    logic        imem_req, imem_ack, ins_valid, fetch_fault;
    logic [31:0] imem_addr, imem_rdata, ins, PC, PCp4;
    logic        ack_en = 1'b0;

    int n_cmp = 0, n_bad = 0, xfer_total = 0, n_ack = 0;
    int min_wait = 0, max_wait = 0;
    int cnt = 0;
    bit busy = 1'b0;
    logic [31:0] held_addr;

    typedef struct { logic [31:0] pc; logic [31:0] ins; } exp_t;
    exp_t exp_q[$];
    bit m_active = 1'b0, m_fault = 1'b0;

    always #5 clk = ~clk;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A3C_96E1;
    endfunction

    assign imem_rdata = memfn(imem_addr);
    assign imem_ack   = imem_req & ack_en;

    fetch_unit #(.QDEPTH(QDEPTH), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst_n(rst_n), .INT(INT), .entryPoint(entryPoint),
        .redir_valid(redir_valid), .redir_pc(redir_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .ins_valid(ins_valid), .ins_ready(ins_ready), .ins(ins), .PC(PC), .PCp4(PCp4),
        .fetch_fault(fetch_fault)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: after a load to target T, decode must see T, T+4, T+8, ... in order.
    task automatic model_load(input bit is_int, input logic [31:0] tgt);
        logic [31:0] t, a;
        t = tgt;
        if (!is_int && (!m_active || m_fault)) return;
        exp_q.delete();
        if (is_int) m_fault = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
        if (t[1:0] != 2'b00) begin
            m_fault  = 1'b1;
            m_active = 1'b0;
            return;
        end
`else
        t[1:0] = 2'b00;
`endif
        m_active = 1'b1;
        for (int i = 0; i < 400; i++) begin
            a = t + 32'(i * 4);
            exp_q.push_back('{a, memfn(a)});
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ctl(input bit di, input logic [31:0] ep, input bit dr, input logic [31:0] rp);
        INT = di; entryPoint = ep; redir_valid = dr; redir_pc = rp;
        @(posedge clk);
        if (di) model_load(1'b1, ep);
        else if (dr) model_load(1'b0, rp);
        #1;
        INT = 1'b0; redir_valid = 1'b0;
    endtask

    task automatic wait_valid(input string nm);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (ins_valid) begin ok = 1'b1; break; end
            step();
        end
        if (!ok) begin
            n_cmp++; n_bad++;
            $display("FAIL %s: ins_valid never rose within 40 cycles", nm);
        end
    endtask

    // Memory responder: random per-request latency, request must stay put until acked.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (!rst_n) begin
                busy = 1'b0; ack_en = 1'b0;
            end else if (imem_req) begin
                if (!busy) begin
                    busy = 1'b1; held_addr = imem_addr;
                    cnt = $urandom_range(max_wait, min_wait);
                end else begin
                    check("addr_hold", imem_addr, held_addr);
                end
                if (cnt == 0) begin
                    ack_en = 1'b1; busy = 1'b0; n_ack++;
                end else begin
                    ack_en = 1'b0; cnt--;
                end
            end else begin
                ack_en = 1'b0; busy = 1'b0;
            end
        end
    end

    // Monitor: every decode transfer is checked against the head of the expected stream.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                if (ins_valid && ins_ready) begin
                    xfer_total++;
                    if (exp_q.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL xfer_unexpected: got PC %h with nothing expected", PC);
                    end else begin
                        e = exp_q.pop_front();
                        check("xfer_pc", PC, e.pc);
                        check("xfer_ins", ins, e.ins);
                        check("xfer_pcp4", PCp4, e.pc + 32'd4);
                    end
                end else if (!ins_valid) begin
                    check("empty_nop", ins, NOP);
                end
                check("fault", {31'd0, fetch_fault}, {31'd0, m_fault});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int r, a0, x0;
        logic [31:0] t;
        rst_n = 1'b0; INT = 1'b0; redir_valid = 1'b0; ins_ready = 1'b1;
        entryPoint = '0; redir_pc = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_valid", {31'd0, ins_valid}, 32'd0);
        check("rst_ins", ins, NOP);
        check("rst_pc", PC, 32'h0);
        check("rst_pcp4", PCp4, 32'h4);
        check("rst_fault", {31'd0, fetch_fault}, 32'd0);
        rst_n = 1'b1;
        repeat (3) step();
        check("idle_req", {31'd0, imem_req}, 32'd0);

        // Zero-wait stream from 0x28
        ctl(1'b1, 32'h28, 1'b0, 32'h0);
        check("int_req", {31'd0, imem_req}, 32'd1);
        check("int_addr", imem_addr, 32'h28);
        check("int_valid_early", {31'd0, ins_valid}, 32'd0);
        step();
        check("first_valid", {31'd0, ins_valid}, 32'd1);
        check("first_pc", PC, 32'h28);
        x0 = xfer_total;
        repeat (10) step();
        check("throughput", 32'(xfer_total - x0), 32'd10);

        // Stall from a fresh INT: exactly QDEPTH words fetched, then requests stop
        ins_ready = 1'b0;
        ctl(1'b1, 32'h200, 1'b0, 32'h0);
        a0 = n_ack;
        repeat (5) step();
        check("stall_acks", 32'(n_ack - a0), 32'(QDEPTH));
        check("stall_req", {31'd0, imem_req}, 32'd0);
        check("stall_pc", PC, 32'h200);
        ins_ready = 1'b1;
        repeat (5) step();

        // Redirect while a slow request is outstanding
        min_wait = 3; max_wait = 3;
        ctl(1'b1, 32'h300, 1'b0, 32'h0);
        r = 0;
        for (int i = 0; i < 20; i++) begin
            #2;
            if (busy && cnt > 0) begin r = 1; break; end
            @(posedge clk); #1;
        end
        if (r == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL drain_setup: no outstanding request observed");
        end
        ctl(1'b0, 32'h0, 1'b1, 32'h100);
        wait_valid("drain_wait");
        check("drain_pc", PC, 32'h100);
        min_wait = 0; max_wait = 0;
        repeat (3) step();

        // INT beats a simultaneous redirect
        ctl(1'b1, 32'h40, 1'b1, 32'h80);
        wait_valid("prio_wait");
        check("prio_pc", PC, 32'h40);

        // PC wrap at the top of the address space
        ins_ready = 1'b0;
        ctl(1'b1, 32'hFFFF_FFF8, 1'b0, 32'h0);
        repeat (4) step();
        check("wrap_head", PC, 32'hFFFF_FFF8);
        ins_ready = 1'b1;
        step();
        ins_ready = 1'b0;
        check("wrap_pc", PC, 32'hFFFF_FFFC);
        check("wrap_pcp4", PCp4, 32'h0);
        check("wrap_addr", imem_addr, 32'h0);
        ins_ready = 1'b1;
        repeat (4) step();

        // Misaligned redirect target
        ctl(1'b0, 32'h0, 1'b1, 32'h102);
`ifdef FETCH_ALIGN_CHECK_EN
        repeat (3) step();
        check("align_fault", {31'd0, fetch_fault}, 32'd1);
        check("align_req", {31'd0, imem_req}, 32'd0);
        check("align_valid", {31'd0, ins_valid}, 32'd0);
        ctl(1'b1, 32'h28, 1'b0, 32'h0);
        check("align_clear", {31'd0, fetch_fault}, 32'd0);
`else
        wait_valid("align_wait");
        check("align_pc", PC, 32'h100);
`endif
        repeat (3) step();

        // Reset in the middle of a slow transaction
        min_wait = 3; max_wait = 3;
        ctl(1'b1, 32'h500, 1'b0, 32'h0);
        step();
        rst_n = 1'b0;
        exp_q.delete(); m_active = 1'b0; m_fault = 1'b0;
        step();
        check("mid_rst_req", {31'd0, imem_req}, 32'd0);
        check("mid_rst_valid", {31'd0, ins_valid}, 32'd0);
        check("mid_rst_pc", PC, 32'h0);
        rst_n = 1'b1;
        min_wait = 0; max_wait = 2;
        step();
        ctl(1'b1, 32'h1000, 1'b0, 32'h0);

        // Random traffic
        for (int c = 0; c < 800; c++) begin
            ins_ready = ($urandom_range(9, 0) < 7);
            r = $urandom_range(99, 0);
            t = $urandom;
            if ($urandom_range(3, 0) != 0) t[1:0] = 2'b00;
            if (r < 2)       ctl(1'b1, t, ($urandom_range(1, 0) == 1), $urandom);
            else if (r < 8)  ctl(1'b0, 32'h0, 1'b1, t);
            else             step();
        end
        ins_ready = 1'b1;
        repeat (10) step();
        check("enough_xfers", {31'd0, (xfer_total > 200)}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
